// File: rtl/core_ex_pkg.sv
// Shared types and constants for the execute stage and its mul/div unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package core_ex_pkg;

  // R-type funct codes decoded when aluop == 2'b10
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLTU  = 6'b101011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
    ALU_SLT, ALU_SLTU, ALU_MFHI, ALU_MFLO, ALU_MULDIV
  } alu_ctrl_e;

  typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_DONE} md_state_e;

  // Encoding matches funct[1:0] of the mul/div instructions
  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  function automatic logic md_is_signed(input md_op_e op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/core_muldiv.sv
// Iterative multiply/divide unit with HI/LO result registers.
// Latency: start accepted in IDLE, DATA_W BUSY cycles, one DONE cycle, then IDLE.
// Backpressure: none; start is ignored unless IDLE, caller stalls on busy.
// Ports: clk/rst (sync, active-high); start/op/a/b request; busy/done status; hi/lo results.
module core_muldiv
  import core_ex_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  md_op_e            op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam int CW = $clog2(DATA_W);
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  md_state_e         state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              is_div_q, is_div_d;
  logic              neg_q, neg_d;      // product / quotient sign
  logic              neg_r_q, neg_r_d;  // remainder sign (dividend sign)
  logic              div0_q, div0_d;
  logic [DATA_W-1:0] a_raw_q, a_raw_d;
  logic [DATA_W-1:0] opb_q, opb_d;      // multiplicand or divisor magnitude
  logic [DATA_W-1:0] p_hi_q, p_hi_d;    // partial product high / remainder
  logic [DATA_W-1:0] p_lo_q, p_lo_d;    // multiplier / dividend->quotient
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;

  logic                neg_a, neg_b, ge;
  logic [DATA_W-1:0]   mag_a, mag_b, addend, diff, it_hi, it_lo, q_fix, r_fix;
  logic [DATA_W:0]     sum, shifted;
  logic [2*DATA_W-1:0] prod, prod_fix;

  always_comb begin
    neg_a = md_is_signed(op) & a[DATA_W-1];
    neg_b = md_is_signed(op) & b[DATA_W-1];
    mag_a = neg_a ? -a : a;
    mag_b = neg_b ? -b : b;

    // Shift-add step: add multiplicand when the multiplier LSB is set, shift right.
    addend = p_lo_q[0] ? opb_q : {DATA_W{1'b0}};
    sum    = {1'b0, p_hi_q} + {1'b0, addend};

    // Restoring step: bring in the next dividend bit, subtract if it fits.
    // The difference always fits in DATA_W bits when taken, so a narrow subtract is exact.
    shifted = {p_hi_q, p_lo_q[DATA_W-1]};
    ge      = shifted >= {1'b0, opb_q};
    diff    = shifted[DATA_W-1:0] - opb_q;

    if (is_div_q) begin
      it_hi = ge ? diff : shifted[DATA_W-1:0];
      it_lo = {p_lo_q[DATA_W-2:0], ge};
    end else begin
      it_hi = sum[DATA_W:1];
      it_lo = {sum[0], p_lo_q[DATA_W-1:1]};
    end

    // Sign fix-up applied to the final iteration's output
    prod     = {it_hi, it_lo};
    prod_fix = neg_q ? -prod : prod;
    q_fix    = neg_q ? -it_lo : it_lo;
    r_fix    = neg_r_q ? -it_hi : it_hi;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    neg_r_d  = neg_r_q;
    div0_d   = div0_q;
    a_raw_d  = a_raw_q;
    opb_d    = opb_q;
    p_hi_d   = p_hi_q;
    p_lo_d   = p_lo_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    case (state_q)
      MD_IDLE: begin
        if (start) begin
          state_d  = MD_BUSY;
          cnt_d    = '0;
          is_div_d = op[1];
          neg_d    = neg_a ^ neg_b;
          neg_r_d  = neg_a;
          div0_d   = (b == '0);
          a_raw_d  = a;
          opb_d    = mag_b;
          p_hi_d   = '0;
          p_lo_d   = mag_a;
        end
      end
      MD_BUSY: begin
        p_hi_d = it_hi;
        p_lo_d = it_lo;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = MD_DONE;
          cnt_d   = '0;
          if (!is_div_q) begin
            hi_d = prod_fix[2*DATA_W-1:DATA_W];
            lo_d = prod_fix[DATA_W-1:0];
          end else if (div0_q) begin
            hi_d = a_raw_q;
            lo_d = '1;
          end else begin
            hi_d = r_fix;
            lo_d = q_fix;
          end
        end
      end
      MD_DONE: state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= MD_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      neg_r_q  <= 1'b0;
      div0_q   <= 1'b0;
      a_raw_q  <= '0;
      opb_q    <= '0;
      p_hi_q   <= '0;
      p_lo_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      neg_r_q  <= neg_r_d;
      div0_q   <= div0_d;
      a_raw_q  <= a_raw_d;
      opb_q    <= opb_d;
      p_hi_q   <= p_hi_d;
      p_lo_q   <= p_lo_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy = (state_q == MD_BUSY);
  assign done = (state_q == MD_DONE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: rtl/core_ex_md.sv
// Execute stage: operand forwarding, ALU control, single-cycle ALU, iterative mul/div.
// Latency: ALU ops combinational; mul/div occupy EX for DATA_W+2 cycles.
// Backpressure: ex_stall holds IF/ID/EX while a mul/div is starting or busy.
// Ports: ID/EX operands and control in; MEM/WB forwarding in; alu_result, data_to_mem,
//        ex_dest_rd, zero, ex_stall out.
module core_ex_md
  import core_ex_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] alusrc_a,
  input  logic [DATA_W-1:0] alusrc_b,
  input  logic [DATA_W-1:0] id_ex_sign_extend,
  input  logic [1:0]        aluop,
  input  logic [5:0]        inst_fun,
  input  logic              regdst,
  input  logic              alusrc,
  input  logic [REG_AW-1:0] id_ex_rs,
  input  logic [REG_AW-1:0] id_ex_rt,
  input  logic [REG_AW-1:0] id_ex_rd,
  input  logic              mem_regwrite,
  input  logic              wb_regwrite,
  input  logic [REG_AW-1:0] mem_regrd,
  input  logic [REG_AW-1:0] wb_regrd,
  input  logic [DATA_W-1:0] mem_reg_data,
  input  logic [DATA_W-1:0] wb_reg_data,
  output logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] data_to_mem,
  output logic [REG_AW-1:0] ex_dest_rd,
  output logic              zero,
  output logic              ex_stall
);

  logic [DATA_W-1:0] fwd_a, fwd_b, op_b, res;
  logic [DATA_W-1:0] md_hi, md_lo;
  logic              md_busy, md_done, md_start_vld;
  alu_ctrl_e         ctrl;

  // Forwarding: the younger MEM result wins over WB; r0 never forwards.
  always_comb begin
    fwd_a = alusrc_a;
    if (mem_regwrite && (mem_regrd != '0) && (mem_regrd == id_ex_rs))
      fwd_a = mem_reg_data;
    else if (wb_regwrite && (wb_regrd != '0) && (wb_regrd == id_ex_rs))
      fwd_a = wb_reg_data;

    fwd_b = alusrc_b;
    if (mem_regwrite && (mem_regrd != '0) && (mem_regrd == id_ex_rt))
      fwd_b = mem_reg_data;
    else if (wb_regwrite && (wb_regrd != '0) && (wb_regrd == id_ex_rt))
      fwd_b = wb_reg_data;

    op_b = alusrc ? id_ex_sign_extend : fwd_b;
  end

  always_comb begin
    ctrl = ALU_ADD;
    case (aluop)
      2'b01: ctrl = ALU_SUB;
      2'b10: begin
        case (inst_fun)
          F_ADD:   ctrl = ALU_ADD;
          F_SUB:   ctrl = ALU_SUB;
          F_AND:   ctrl = ALU_AND;
          F_OR:    ctrl = ALU_OR;
          F_XOR:   ctrl = ALU_XOR;
          F_NOR:   ctrl = ALU_NOR;
          F_SLT:   ctrl = ALU_SLT;
          F_SLTU:  ctrl = ALU_SLTU;
          F_MFHI:  ctrl = ALU_MFHI;
          F_MFLO:  ctrl = ALU_MFLO;
          F_MULT, F_MULTU, F_DIV, F_DIVU: ctrl = ALU_MULDIV;
          default: ctrl = ALU_ADD;
        endcase
      end
      default: ctrl = ALU_ADD;
    endcase
  end

  always_comb begin
    res = '0;
    case (ctrl)
      ALU_ADD:    res = fwd_a + op_b;
      ALU_SUB:    res = fwd_a - op_b;
      ALU_AND:    res = fwd_a & op_b;
      ALU_OR:     res = fwd_a | op_b;
      ALU_XOR:    res = fwd_a ^ op_b;
      ALU_NOR:    res = ~(fwd_a | op_b);
      ALU_SLT:    res = {{(DATA_W-1){1'b0}}, ($signed(fwd_a) < $signed(op_b))};
      ALU_SLTU:   res = {{(DATA_W-1){1'b0}}, (fwd_a < op_b)};
      ALU_MFHI:   res = md_hi;
      ALU_MFLO:   res = md_lo;
      ALU_MULDIV: res = '0;
      default:    res = '0;
    endcase
  end

  // Start only from IDLE so the held instruction does not relaunch during DONE.
  assign md_start_vld = ex_valid && (ctrl == ALU_MULDIV) && !md_busy && !md_done;
  assign ex_stall     = md_busy || md_start_vld;

  assign alu_result  = res;
  assign data_to_mem = fwd_b;
  assign ex_dest_rd  = (ctrl == ALU_MULDIV) ? '0 : (regdst ? id_ex_rd : id_ex_rt);
  assign zero        = (aluop == 2'b01) && (res == '0);

  core_muldiv #(.DATA_W(DATA_W)) u_muldiv (
    .clk   (clk),
    .rst   (rst),
    .start (md_start_vld),
    .op    (md_op_e'(inst_fun[1:0])),
    .a     (fwd_a),
    .b     (fwd_b),
    .busy  (md_busy),
    .done  (md_done),
    .hi    (md_hi),
    .lo    (md_lo)
  );

endmodule

// File: tb/tb_core_ex_md.sv
// Directed bench for core_ex_md: forwarding, ALU ops, mul/div timing and results, reset abort.
// Latency: n/a.
// Backpressure: n/a.
module tb_core_ex_md;
  localparam int DATA_W = 32;
  localparam int REG_AW = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              ex_valid;
  logic [DATA_W-1:0] alusrc_a, alusrc_b, id_ex_sign_extend;
  logic [1:0]        aluop;
  logic [5:0]        inst_fun;
  logic              regdst, alusrc;
  logic [REG_AW-1:0] id_ex_rs, id_ex_rt, id_ex_rd;
  logic              mem_regwrite, wb_regwrite;
  logic [REG_AW-1:0] mem_regrd, wb_regrd;
  logic [DATA_W-1:0] mem_reg_data, wb_reg_data;
  logic [DATA_W-1:0] alu_result, data_to_mem;
  logic [REG_AW-1:0] ex_dest_rd;
  logic              zero, ex_stall;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  core_ex_md #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid),
    .alusrc_a(alusrc_a), .alusrc_b(alusrc_b), .id_ex_sign_extend(id_ex_sign_extend),
    .aluop(aluop), .inst_fun(inst_fun), .regdst(regdst), .alusrc(alusrc),
    .id_ex_rs(id_ex_rs), .id_ex_rt(id_ex_rt), .id_ex_rd(id_ex_rd),
    .mem_regwrite(mem_regwrite), .wb_regwrite(wb_regwrite),
    .mem_regrd(mem_regrd), .wb_regrd(wb_regrd),
    .mem_reg_data(mem_reg_data), .wb_reg_data(wb_reg_data),
    .alu_result(alu_result), .data_to_mem(data_to_mem), .ex_dest_rd(ex_dest_rd),
    .zero(zero), .ex_stall(ex_stall)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ex_valid = 1'b0; alusrc_a = '0; alusrc_b = '0; id_ex_sign_extend = '0;
    aluop = 2'b00; inst_fun = 6'b100000; regdst = 1'b1; alusrc = 1'b0;
    id_ex_rs = 5'd1; id_ex_rt = 5'd2; id_ex_rd = 5'd3;
    mem_regwrite = 1'b0; wb_regwrite = 1'b0; mem_regrd = '0; wb_regrd = '0;
    mem_reg_data = '0; wb_reg_data = '0;
  endtask

  // R-type instruction in EX with no forwarding: rs=1, rt=2, rd=3
  task automatic set_r(input logic [5:0] fun, input logic [31:0] a, input logic [31:0] b);
    clear_inputs();
    ex_valid = 1'b1; aluop = 2'b10; inst_fun = fun; alusrc_a = a; alusrc_b = b;
  endtask

  task automatic read_hilo(output logic [31:0] lo, output logic [31:0] hi);
    set_r(6'b010010, '0, '0); #1; lo = alu_result;
    set_r(6'b010000, '0, '0); #1; hi = alu_result;
    clear_inputs();
  endtask

  // Issue a mul/div at T and count stalled cycles until ex_stall drops (DONE), then go to IDLE.
  task automatic run_md(input logic [5:0] fun, input logic [31:0] a, input logic [31:0] b,
                        output int cycles);
    set_r(fun, a, b); #1;
    cycles = 0;
    while (ex_stall === 1'b1 && cycles < 100) begin
      tick(); #1;
      cycles++;
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_reset();
    logic [31:0] lo, hi;
    clear_inputs();
    rst = 1'b1; tick(); tick(); rst = 1'b0; #1;
    n_cmp++; if (ex_stall !== 1'b0) begin n_err++; $display("FAIL reset_stall got %0b want 0", ex_stall); end
    n_cmp++; if (zero !== 1'b0) begin n_err++; $display("FAIL reset_zero got %0b want 0", zero); end
    read_hilo(lo, hi);
    n_cmp++; if (lo !== 32'h0) begin n_err++; $display("FAIL reset_lo got %h want 0", lo); end
    n_cmp++; if (hi !== 32'h0) begin n_err++; $display("FAIL reset_hi got %h want 0", hi); end
  endtask

  task automatic test_forward();
    clear_inputs();
    ex_valid = 1'b1; id_ex_rs = 5'd5; id_ex_rt = 5'd6; alusrc_a = 32'd100; alusrc_b = 32'd1;
    mem_regwrite = 1'b1; mem_regrd = 5'd5; mem_reg_data = 32'd7;
    wb_regwrite = 1'b1; wb_regrd = 5'd5; wb_reg_data = 32'd9; #1;
    n_cmp++; if (alu_result !== 32'd8) begin n_err++; $display("FAIL fwd_mem_wins got %0d want 8", alu_result); end
    mem_regrd = 5'd0; #1;
    n_cmp++; if (alu_result !== 32'd10) begin n_err++; $display("FAIL fwd_wb got %0d want 10", alu_result); end
    mem_regrd = 5'd5; mem_regwrite = 1'b0; #1;
    n_cmp++; if (alu_result !== 32'd10) begin n_err++; $display("FAIL fwd_mem_nowrite got %0d want 10", alu_result); end
    wb_regwrite = 1'b0; #1;
    n_cmp++; if (alu_result !== 32'd101) begin n_err++; $display("FAIL fwd_none got %0d want 101", alu_result); end
    id_ex_rt = 5'd5; mem_regwrite = 1'b1; #1;
    n_cmp++; if (data_to_mem !== 32'd7) begin n_err++; $display("FAIL fwd_rt_store got %0d want 7", data_to_mem); end
    n_cmp++; if (alu_result !== 32'd14) begin n_err++; $display("FAIL fwd_both got %0d want 14", alu_result); end
    alusrc = 1'b1; id_ex_sign_extend = 32'h20; #1;
    n_cmp++; if (alu_result !== 32'h27) begin n_err++; $display("FAIL imm_b got %h want 27", alu_result); end
    n_cmp++; if (data_to_mem !== 32'd7) begin n_err++; $display("FAIL imm_store got %0d want 7", data_to_mem); end
    alusrc = 1'b0; id_ex_rs = 5'd0; id_ex_rt = 5'd0; alusrc_a = 32'd4; alusrc_b = 32'd11;
    mem_regrd = 5'd0; wb_regrd = 5'd0; wb_regwrite = 1'b1; #1;
    n_cmp++; if (alu_result !== 32'd15) begin n_err++; $display("FAIL fwd_r0 got %0d want 15", alu_result); end
    n_cmp++; if (data_to_mem !== 32'd11) begin n_err++; $display("FAIL fwd_r0_store got %0d want 11", data_to_mem); end
  endtask

  task automatic test_alu_ops();
    logic [5:0]  f;
    logic [31:0] e;
    for (int i = 0; i < 7; i++) begin
      case (i)
        0: begin f = 6'b100100; e = 32'h00F00034; end
        1: begin f = 6'b100101; e = 32'hFFF012FF; end
        2: begin f = 6'b100110; e = 32'hFF0012CB; end
        3: begin f = 6'b100111; e = 32'h000FED00; end
        4: begin f = 6'b111111; e = 32'h00E01333; end
        5: begin f = 6'b100000; e = 32'h00E01333; end
        default: begin f = 6'b100010; e = 32'hE1001135; end
      endcase
      set_r(f, 32'hF0F01234, 32'h0FF000FF); #1;
      n_cmp++; if (alu_result !== e) begin n_err++; $display("FAIL alu_fun_%b got %h want %h", f, alu_result, e); end
    end
    n_cmp++; if (ex_dest_rd !== 5'd3) begin n_err++; $display("FAIL dest_rd got %0d want 3", ex_dest_rd); end
    regdst = 1'b0; #1;
    n_cmp++; if (ex_dest_rd !== 5'd2) begin n_err++; $display("FAIL dest_rt got %0d want 2", ex_dest_rd); end
    set_r(6'b101010, 32'hFFFFFFFF, 32'd1); #1;
    n_cmp++; if (alu_result !== 32'd1) begin n_err++; $display("FAIL slt got %h want 1", alu_result); end
    set_r(6'b101011, 32'hFFFFFFFF, 32'd1); #1;
    n_cmp++; if (alu_result !== 32'd0) begin n_err++; $display("FAIL sltu got %h want 0", alu_result); end
    set_r(6'b100010, 32'd3, 32'd5); #1;
    n_cmp++; if (alu_result !== 32'hFFFFFFFE) begin n_err++; $display("FAIL sub_wrap got %h want fffffffe", alu_result); end
    set_r(6'b100000, 32'd3, 32'd3); aluop = 2'b01; #1;
    n_cmp++; if (zero !== 1'b1) begin n_err++; $display("FAIL zero_beq got %0b want 1", zero); end
    alusrc_a = 32'd5; #1;
    n_cmp++; if (zero !== 1'b0 || alu_result !== 32'd2) begin n_err++; $display("FAIL sub_nz got z=%0b r=%0d want z=0 r=2", zero, alu_result); end
    alusrc_a = 32'd1; alusrc_b = 32'hFFFFFFFF; aluop = 2'b00; #1;
    n_cmp++; if (alu_result !== 32'd0 || zero !== 1'b0) begin n_err++; $display("FAIL add_zero_flag got r=%h z=%0b want r=0 z=0", alu_result, zero); end
    alusrc_a = 32'd3; alusrc_b = 32'd5; aluop = 2'b11; #1;
    n_cmp++; if (alu_result !== 32'd8) begin n_err++; $display("FAIL aluop11 got %0d want 8", alu_result); end
    clear_inputs();
  endtask

  task automatic test_mult_timing();
    logic [31:0] lo, hi;
    set_r(6'b011000, 32'hFFFFFFFD, 32'd5); #1;
    n_cmp++; if (ex_stall !== 1'b1) begin n_err++; $display("FAIL mult_stall_T got %0b want 1", ex_stall); end
    n_cmp++; if (alu_result !== 32'd0 || ex_dest_rd !== 5'd0) begin n_err++; $display("FAIL mult_nowrite got r=%h d=%0d want 0/0", alu_result, ex_dest_rd); end
    for (int k = 1; k <= 32; k++) begin
      tick();
      n_cmp++; if (ex_stall !== 1'b1) begin n_err++; $display("FAIL mult_stall_T+%0d got %0b want 1", k, ex_stall); end
    end
    tick();
    n_cmp++; if (ex_stall !== 1'b0) begin n_err++; $display("FAIL mult_done_stall got %0b want 0", ex_stall); end
    tick();
    read_hilo(lo, hi);
    n_cmp++; if (lo !== 32'hFFFFFFF1) begin n_err++; $display("FAIL mult_lo got %h want fffffff1", lo); end
    n_cmp++; if (hi !== 32'hFFFFFFFF) begin n_err++; $display("FAIL mult_hi got %h want ffffffff", hi); end
  endtask

  task automatic test_muldiv_results();
    logic [5:0]  f;
    logic [31:0] a, b, elo, ehi, lo, hi;
    int          cyc;
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: begin f = 6'b011010; a = 32'hFFFFFFF9; b = 32'd2;          elo = 32'hFFFFFFFD; ehi = 32'hFFFFFFFF; end
        1: begin f = 6'b011011; a = 32'd7;        b = 32'd0;          elo = 32'hFFFFFFFF; ehi = 32'd7;        end
        2: begin f = 6'b011010; a = 32'h80000000; b = 32'hFFFFFFFF;   elo = 32'h80000000; ehi = 32'd0;        end
        3: begin f = 6'b011011; a = 32'd100;      b = 32'd7;          elo = 32'd14;       ehi = 32'd2;        end
        4: begin f = 6'b011010; a = 32'd7;        b = 32'hFFFFFFFE;   elo = 32'hFFFFFFFD; ehi = 32'd1;        end
        default: begin f = 6'b011001; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; elo = 32'h00000001; ehi = 32'hFFFFFFFE; end
      endcase
      run_md(f, a, b, cyc);
      n_cmp++; if (cyc !== 33) begin n_err++; $display("FAIL md%0d_stall_cycles got %0d want 33", i, cyc); end
      read_hilo(lo, hi);
      n_cmp++; if (lo !== elo) begin n_err++; $display("FAIL md%0d_lo got %h want %h", i, lo, elo); end
      n_cmp++; if (hi !== ehi) begin n_err++; $display("FAIL md%0d_hi got %h want %h", i, hi, ehi); end
    end
  endtask

  task automatic test_mflo_busy();
    logic [31:0] lo, hi;
    set_r(6'b011001, 32'd6, 32'd7); #1;
    tick();
    // EX now presents mflo; forwarding sources start matching rs and toggling
    set_r(6'b010010, 32'd6, 32'd7);
    mem_regwrite = 1'b1; mem_regrd = 5'd1; mem_reg_data = 32'h1234;
    wb_regwrite = 1'b1; wb_regrd = 5'd2; wb_reg_data = 32'h5678; #1;
    n_cmp++; if (ex_stall !== 1'b1) begin n_err++; $display("FAIL mflo_busy_stall_T+1 got %0b want 1", ex_stall); end
    for (int k = 2; k <= 32; k++) begin
      tick();
      mem_reg_data = 32'(k * 3); wb_reg_data = 32'(k + 1000); #1;
      n_cmp++; if (ex_stall !== 1'b1) begin n_err++; $display("FAIL mflo_busy_stall_T+%0d got %0b want 1", k, ex_stall); end
    end
    tick();
    n_cmp++; if (ex_stall !== 1'b0) begin n_err++; $display("FAIL mflo_done_stall got %0b want 0", ex_stall); end
    n_cmp++; if (alu_result !== 32'd42) begin n_err++; $display("FAIL mflo_done_val got %0d want 42", alu_result); end
    tick();
    read_hilo(lo, hi);
    n_cmp++; if (hi !== 32'd0) begin n_err++; $display("FAIL mflo_busy_hi got %h want 0", hi); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] lo, hi;
    set_r(6'b011001, 32'h0000FFFF, 32'h0000FFFF); #1;
    for (int k = 1; k <= 10; k++) tick();
    rst = 1'b1; ex_valid = 1'b0;
    tick();
    rst = 1'b0; #1;
    n_cmp++; if (ex_stall !== 1'b0) begin n_err++; $display("FAIL rst_mid_stall got %0b want 0", ex_stall); end
    read_hilo(lo, hi);
    n_cmp++; if (lo !== 32'd0 || hi !== 32'd0) begin n_err++; $display("FAIL rst_mid_hilo got %h/%h want 0/0", hi, lo); end
    for (int k = 0; k < 30; k++) tick();
    read_hilo(lo, hi);
    n_cmp++; if (lo !== 32'd0 || hi !== 32'd0) begin n_err++; $display("FAIL rst_abort_nowrite got %h/%h want 0/0", hi, lo); end
    clear_inputs();
    aluop = 2'b10; inst_fun = 6'b011000; alusrc_a = 32'd5; alusrc_b = 32'd5; #1;
    n_cmp++; if (ex_stall !== 1'b0) begin n_err++; $display("FAIL bubble_stall got %0b want 0", ex_stall); end
    tick();
    n_cmp++; if (ex_stall !== 1'b0) begin n_err++; $display("FAIL bubble_nostart got %0b want 0", ex_stall); end
    clear_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_forward();
    test_alu_ops();
    test_mult_timing();
    test_muldiv_results();
    test_mflo_busy();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
